// File: rtl/apb2axi_apb_completer.sv
// APB completer: turns one-hot-selected APB transfers into a valid/ready core request and returns the core response.
// Optional response timeout is built when APB2AXI_COMPLETER_TIMEOUT_EN is defined.
module apb2axi_apb_completer #(
  parameter  int ADDR_WIDTH  = 32,
  parameter  int DATA_WIDTH  = 32,
  parameter  int NUM_SEL     = 2,
  parameter  int TIMEOUT_CYC = 16,
  localparam int SEL_W       = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [NUM_SEL-1:0]    PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [SEL_W-1:0]      req_sel,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_write,
  output logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  rsp_err,
  output logic                  stale_rsp
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, RESP} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   prdata_d, req_wdata_d;
  logic [ADDR_WIDTH-1:0]   req_addr_d;
  logic [SEL_W-1:0]        req_sel_d, sel_idx;
  logic                    pready_d, pslverr_d, req_valid_d, req_write_d;
  logic                    rsp_ready_d, stale_d;
  logic [4:0]              sel_cnt;
  logic                    setup;

`ifdef APB2AXI_COMPLETER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    sel_cnt = '0;
    sel_idx = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      if (PSEL[i]) begin
        sel_cnt = sel_cnt + 5'd1;
        sel_idx = SEL_W'(i);
      end
    end
  end

  assign setup = (|PSEL) && !PENABLE;

  always_comb begin
    state_d     = state_q;
    prdata_d    = '0;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    req_valid_d = req_valid;
    req_sel_d   = req_sel;
    req_addr_d  = req_addr;
    req_write_d = req_write;
    req_wdata_d = req_wdata;
    // any response accepted outside WAIT_RSP belongs to no live transfer
    stale_d     = rsp_valid && rsp_ready && (state_q != WAIT_RSP);
`ifdef APB2AXI_COMPLETER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (setup) begin
          if (sel_cnt == 5'd1) begin
            req_valid_d = 1'b1;
            req_sel_d   = sel_idx;
            req_addr_d  = PADDR;
            req_write_d = PWRITE;
            req_wdata_d = PWDATA;
            state_d     = REQ;
          end else begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            state_d   = RESP;
          end
        end
      end
      REQ: begin
        if (req_valid && req_ready) begin
          req_valid_d = 1'b0;
`ifdef APB2AXI_COMPLETER_TIMEOUT_EN
          cnt_d       = '0;
`endif
          state_d     = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rsp_valid) begin
          pready_d  = 1'b1;
          pslverr_d = rsp_err;
          prdata_d  = req_write ? '0 : rsp_rdata;
          state_d   = RESP;
        end else begin
`ifdef APB2AXI_COMPLETER_TIMEOUT_EN
          if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            state_d   = RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rsp_ready_d = (state_d != REQ);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      PRDATA    <= '0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      req_valid <= 1'b0;
      req_sel   <= '0;
      req_addr  <= '0;
      req_write <= 1'b0;
      req_wdata <= '0;
      rsp_ready <= 1'b0;
      stale_rsp <= 1'b0;
    end else begin
      state_q   <= state_d;
      PRDATA    <= prdata_d;
      PREADY    <= pready_d;
      PSLVERR   <= pslverr_d;
      req_valid <= req_valid_d;
      req_sel   <= req_sel_d;
      req_addr  <= req_addr_d;
      req_write <= req_write_d;
      req_wdata <= req_wdata_d;
      rsp_ready <= rsp_ready_d;
      stale_rsp <= stale_d;
    end
  end

`ifdef APB2AXI_COMPLETER_TIMEOUT_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_apb2axi_apb_completer.sv
// Randomized bench for apb2axi_apb_completer against a transaction-level reference model.
`timescale 1ns/1ps
module tb_apb2axi_apb_completer;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NS  = 2;
  localparam int TMO = 16;
`ifdef APB2AXI_COMPLETER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic [AW-1:0] PADDR;
  logic [NS-1:0] PSEL;
  logic          PENABLE, PWRITE;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;
  logic          req_valid, req_ready, req_write;
  logic [0:0]    req_sel;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, rsp_rdata;
  logic          rsp_valid, rsp_ready, rsp_err, stale_rsp;

  always #5 PCLK = ~PCLK;

  apb2axi_apb_completer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SEL(NS), .TIMEOUT_CYC(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stale_rsp(stale_rsp)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pready"},  PREADY, 0);
    chk({tag, "_pslverr"}, PSLVERR, 0);
    chk({tag, "_prdata"},  PRDATA, 0);
    chk({tag, "_reqv"},    req_valid, 0);
    chk({tag, "_reqaddr"}, req_addr, 0);
    chk({tag, "_reqsel"},  req_sel, 0);
    chk({tag, "_reqwr"},   req_write, 0);
    chk({tag, "_reqwd"},   req_wdata, 0);
    chk({tag, "_rsprdy"},  rsp_ready, 0);
    chk({tag, "_stale"},   stale_rsp, 0);
  endtask

  // One complete APB transfer; expectations come from the transfer-level rules only.
  task automatic xfer(input logic [NS-1:0] sel, input logic wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input int dreq, input int drsp,
                      input logic err, input logic [DW-1:0] rd);
    bit            multi, tmo, seen;
    int            exp_wait, n;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    multi     = $countones(sel) > 1;
    tmo       = TMO_EN && (drsp >= TMO);
    exp_wait  = tmo ? TMO : drsp + 1;
    exp_err   = multi || tmo || err;
    exp_rdata = (multi || tmo || wr) ? '0 : rd;

    PSEL = sel; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    req_ready = 1'b0; rsp_valid = 1'b0;
    chk("setup_pready", PREADY, 0);
    tick;
    PENABLE = 1'b1;
    if (multi) begin
      chk("multi_pready", PREADY, 1);
      chk("multi_pslverr", PSLVERR, exp_err);
      chk("multi_prdata", PRDATA, exp_rdata);
      chk("multi_reqv", req_valid, 0);
    end else begin
      PADDR = ~addr; PWDATA = ~wd;
      for (int k = 0; k <= dreq; k++) begin
        req_ready = (k == dreq);
        chk("req_valid", req_valid, 1);
        chk("req_sel", req_sel, $clog2(sel));
        chk("req_addr", req_addr, addr);
        chk("req_write", req_write, wr);
        chk("req_wdata", req_wdata, wd);
        chk("req_rsprdy", rsp_ready, 0);
        chk("req_pready", PREADY, 0);
        tick;
      end
      req_ready = 1'b0;
      chk("wait_reqv", req_valid, 0);
      chk("wait_rsprdy", rsp_ready, 1);
      n = 0; seen = 0;
      while (!seen && n < 200) begin
        rsp_valid = !tmo && (n == drsp);
        rsp_rdata = rsp_valid ? rd : $urandom;
        rsp_err   = rsp_valid ? err : 1'($urandom);
        tick;
        n++;
        rsp_valid = 1'b0;
        if (PREADY) seen = 1;
      end
      chk("latency", n, exp_wait);
      chk("pslverr", PSLVERR, exp_err);
      chk("prdata", PRDATA, exp_rdata);
    end
    PSEL = '0; PENABLE = 1'b0;
    tick;
    chk("end_pready", PREADY, 0);
    chk("end_pslverr", PSLVERR, 0);
    chk("end_prdata", PRDATA, 0);
  endtask

  // Unsolicited response while idle: consumed, flagged, never completes a transfer.
  task automatic stale_probe;
    rsp_valid = 1'b1; rsp_rdata = $urandom; rsp_err = 1'($urandom);
    tick;
    rsp_valid = 1'b0;
    chk("stale_pulse", stale_rsp, 1);
    chk("stale_pready", PREADY, 0);
    tick;
    chk("stale_clear", stale_rsp, 0);
    chk("stale_pready2", PREADY, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [NS-1:0] s;
    int dr;
    PRESET = 1'b1; PSEL = '0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    req_ready = 0; rsp_valid = 0; rsp_rdata = '0; rsp_err = 0;
    #1;
    chk_all_zero("reset");
    tick; tick;
    #2 PRESET = 1'b0;
    tick;
    chk("idle_rsprdy", rsp_ready, 1);

    xfer(2'b10, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0, 32'h55AA55AA);
    xfer(2'b01, 0, 32'h104, 32'h0, 5, 2, 0, 32'h12345678);
    xfer(2'b11, 1, 32'h200, 32'h1111, 0, 0, 0, 32'h0);
    xfer(2'b01, 0, 32'h300, 32'h0, 1, 30, 0, 32'hABCD0123);
    tick; tick;
    stale_probe();
    xfer(2'b10, 0, 32'h8, 32'h0, 0, 1, 1, 32'hCAFE0001);
    xfer(2'b01, 0, 32'hC, 32'h0, 0, TMO - 1, 0, 32'h0F0F0F0F);

    // asynchronous reset while waiting for the core
    PSEL = 2'b10; PENABLE = 0; PWRITE = 1; PADDR = 32'hF00; PWDATA = 32'h77;
    tick;
    PENABLE = 1; req_ready = 1;
    tick;
    req_ready = 0;
    chk("pre_rst_rsprdy", rsp_ready, 1);
    #2 PRESET = 1'b1;
    #1;
    chk_all_zero("midrst");
    PSEL = '0; PENABLE = 0;
    tick; tick;
    chk("midrst_pready", PREADY, 0);
    #2 PRESET = 1'b0;
    tick;
    xfer(2'b10, 0, 32'h44, 32'h0, 2, 3, 0, 32'h89ABCDEF);

    for (int t = 0; t < 60; t++) begin
      s = NS'($urandom_range(1, 3));
      if (TMO_EN && $urandom_range(0, 7) == 0) dr = $urandom_range(TMO - 2, TMO + 4);
      else dr = $urandom_range(0, 6);
      xfer(s, 1'($urandom), $urandom, $urandom, $urandom_range(0, 4), dr,
           ($urandom_range(0, 3) == 0), $urandom);
      if ($urandom_range(0, 3) == 0) stale_probe();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
